// File: rtl/xor_flags_capture_fifo.sv
// rtl/xor_flags_capture_fifo.sv - capture FIFO for circular-XOR/flags results with sticky flags and counters
//
// Purpose:
//   Registers each {Y,N,Z,C,V} result from the XOR/flags unit into a small
//   show-ahead FIFO with valid/ready handshakes on both sides. Alongside the
//   FIFO it keeps sticky NZCV (OR of every pushed flag set), a saturating
//   count of zero-flagged pushes, and a sticky error bit that records any
//   push whose Z flag disagrees with its Y value.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_i          synchronous reset, active-high, wins over every other event
//   in_valid_i     upstream result valid
//   in_ready_o     FIFO can accept (not full)
//   in_y_i         XOR result Y
//   in_n_i         N flag
//   in_z_i         Z flag
//   in_c_i         C flag
//   in_v_i         V flag
//   out_valid_o    head entry available (not empty)
//   out_ready_i    consumer accepts head
//   out_y_o        head result, 0 when empty
//   out_nzcv_o     head flags {N,Z,C,V}, 0 when empty
//   sticky_nzcv_o  OR of all flags pushed since reset/clear
//   clr_sticky_i   clears sticky_nzcv_o and flag_err_o
//   count_o        occupancy
//   zero_cnt_o     pushes with Z=1, saturating at 255
//   flag_err_o     sticky: some push had Z != (Y==0)

module xor_flags_capture_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [W-1:0]               in_y_i,
    input  logic                       in_n_i,
    input  logic                       in_z_i,
    input  logic                       in_c_i,
    input  logic                       in_v_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [W-1:0]               out_y_o,
    output logic [3:0]                 out_nzcv_o,
    output logic [3:0]                 sticky_nzcv_o,
    input  logic                       clr_sticky_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic [7:0]                 zero_cnt_o,
    output logic                       flag_err_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int EW = W + 4;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    // Each entry packs {Y, N, Z, C, V}.
    logic [EW-1:0] mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic [3:0]    sticky_q, sticky_d;
    logic [7:0]    zero_cnt_q, zero_cnt_d;
    logic          flag_err_q, flag_err_d;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [3:0]    in_flags;
    logic [3:0]    push_flags;
    logic          push_err;
    logic [EW-1:0] head;

    // Handshake status comes only from registered occupancy, so there is no
    // combinational path from in_valid_i/out_ready_i to in_ready_o/out_valid_o.
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign push  = in_valid_i & ~full;
    assign pop   = out_ready_i & ~empty;

    assign in_flags   = {in_n_i, in_z_i, in_c_i, in_v_i};
    assign push_flags = push ? in_flags : 4'b0000;
    assign push_err   = push & (in_z_i != ~|in_y_i);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // A clear still keeps the flags of a push landing in the same cycle.
    always_comb begin
        sticky_d   = clr_sticky_i ? push_flags : (sticky_q | push_flags);
        flag_err_d = clr_sticky_i ? push_err   : (flag_err_q | push_err);
    end

    always_comb begin
        zero_cnt_d = zero_cnt_q;
        if (push && in_z_i && (zero_cnt_q != 8'hFF)) begin
            zero_cnt_d = zero_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            sticky_q   <= 4'b0000;
            zero_cnt_q <= 8'd0;
            flag_err_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            sticky_q   <= sticky_d;
            zero_cnt_q <= zero_cnt_d;
            flag_err_q <= flag_err_d;
        end
    end

    // Storage carries no reset; the output mux hides stale contents when empty.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push) begin
            mem_q[wr_ptr_q] <= {in_y_i, in_flags};
        end
    end

    assign head = mem_q[rd_ptr_q];

    assign in_ready_o    = ~full;
    assign out_valid_o   = ~empty;
    assign out_y_o       = empty ? '0 : head[EW-1:4];
    assign out_nzcv_o    = empty ? 4'b0000 : head[3:0];
    assign sticky_nzcv_o = sticky_q;
    assign count_o       = count_q;
    assign zero_cnt_o    = zero_cnt_q;
    assign flag_err_o    = flag_err_q;

endmodule

// File: tb/tb_xor_flags_capture_fifo.sv
// tb/tb_xor_flags_capture_fifo.sv - table-driven bench for xor_flags_capture_fifo

module tb_xor_flags_capture_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_y;
    logic       in_n, in_z, in_c, in_v;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_y;
    logic [3:0] out_nzcv;
    logic [3:0] sticky_nzcv;
    logic       clr_sticky;
    logic [2:0] count;
    logic [7:0] zero_cnt;
    logic       flag_err;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    xor_flags_capture_fifo #(.DEPTH(4), .W(4)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .in_y_i        (in_y),
        .in_n_i        (in_n),
        .in_z_i        (in_z),
        .in_c_i        (in_c),
        .in_v_i        (in_v),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_y_o       (out_y),
        .out_nzcv_o    (out_nzcv),
        .sticky_nzcv_o (sticky_nzcv),
        .clr_sticky_i  (clr_sticky),
        .count_o       (count),
        .zero_cnt_o    (zero_cnt),
        .flag_err_o    (flag_err)
    );

    typedef struct packed {
        logic       vld;
        logic [3:0] y;
        logic [3:0] nzcv;
        logic       ordy;
        logic       ov;
        logic       ir;
        logic [3:0] ey;
        logic [3:0] enzcv;
        logic [2:0] ecnt;
        logic [3:0] estk;
    } vec_t;

    vec_t vecs [17];

    function automatic vec_t mk(input logic vld, input logic [3:0] y, input logic [3:0] nzcv,
                                input logic ordy, input logic ov, input logic ir,
                                input logic [3:0] ey, input logic [3:0] enzcv,
                                input logic [2:0] ecnt, input logic [3:0] estk);
        vec_t v;
        v.vld = vld; v.y = y; v.nzcv = nzcv; v.ordy = ordy;
        v.ov = ov; v.ir = ir; v.ey = ey; v.enzcv = enzcv; v.ecnt = ecnt; v.estk = estk;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic vld, input logic [3:0] y, input logic [3:0] nzcv,
                         input logic ordy, input logic clr);
        in_valid   = vld;
        in_y       = y;
        {in_n, in_z, in_c, in_v} = nzcv;
        out_ready  = ordy;
        clr_sticky = clr;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // vld  y     nzcv     ordy  ov   ir   ey     enzcv    cnt   sticky
        vecs[0]  = mk(1, 4'hA, 4'b1000, 0, 1, 1, 4'hA, 4'b1000, 3'd1, 4'b1000);
        vecs[1]  = mk(0, 4'h0, 4'b0000, 1, 0, 1, 4'h0, 4'b0000, 3'd0, 4'b1000);
        vecs[2]  = mk(1, 4'h1, 4'b0000, 0, 1, 1, 4'h1, 4'b0000, 3'd1, 4'b1000);
        vecs[3]  = mk(1, 4'h2, 4'b0000, 0, 1, 1, 4'h1, 4'b0000, 3'd2, 4'b1000);
        vecs[4]  = mk(1, 4'h3, 4'b0010, 0, 1, 1, 4'h1, 4'b0000, 3'd3, 4'b1010);
        vecs[5]  = mk(1, 4'h4, 4'b0000, 0, 1, 0, 4'h1, 4'b0000, 3'd4, 4'b1010);
        vecs[6]  = mk(1, 4'h5, 4'b0000, 0, 1, 0, 4'h1, 4'b0000, 3'd4, 4'b1010);
        vecs[7]  = mk(1, 4'h5, 4'b0000, 1, 1, 1, 4'h2, 4'b0000, 3'd3, 4'b1010);
        vecs[8]  = mk(1, 4'h5, 4'b0000, 1, 1, 1, 4'h3, 4'b0010, 3'd3, 4'b1010);
        vecs[9]  = mk(0, 4'h0, 4'b0000, 1, 1, 1, 4'h4, 4'b0000, 3'd2, 4'b1010);
        vecs[10] = mk(0, 4'h0, 4'b0000, 1, 1, 1, 4'h5, 4'b0000, 3'd1, 4'b1010);
        vecs[11] = mk(0, 4'h0, 4'b0000, 1, 0, 1, 4'h0, 4'b0000, 3'd0, 4'b1010);
        vecs[12] = mk(1, 4'h6, 4'b0001, 0, 1, 1, 4'h6, 4'b0001, 3'd1, 4'b1011);
        vecs[13] = mk(1, 4'h7, 4'b0000, 0, 1, 1, 4'h6, 4'b0001, 3'd2, 4'b1011);
        vecs[14] = mk(1, 4'h8, 4'b0000, 1, 1, 1, 4'h7, 4'b0000, 3'd2, 4'b1011);
        vecs[15] = mk(0, 4'h0, 4'b0000, 1, 1, 1, 4'h8, 4'b0000, 3'd1, 4'b1011);
        vecs[16] = mk(0, 4'h0, 4'b0000, 1, 0, 1, 4'h0, 4'b0000, 3'd0, 4'b1011);

        rst = 1'b1;
        drive(0, 4'h0, 4'b0000, 0, 0);
        tick;
        tick;
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_count", count, 0);
        chk("rst_sticky", sticky_nzcv, 0);
        chk("rst_zero_cnt", zero_cnt, 0);
        chk("rst_flag_err", flag_err, 0);
        chk("rst_out_y", out_y, 0);

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].vld, vecs[i].y, vecs[i].nzcv, vecs[i].ordy, 0);
            tick;
            chk($sformatf("v%0d_out_valid", i), out_valid, vecs[i].ov);
            chk($sformatf("v%0d_in_ready", i), in_ready, vecs[i].ir);
            chk($sformatf("v%0d_out_y", i), out_y, vecs[i].ey);
            chk($sformatf("v%0d_out_nzcv", i), out_nzcv, vecs[i].enzcv);
            chk($sformatf("v%0d_count", i), count, vecs[i].ecnt);
            chk($sformatf("v%0d_sticky", i), sticky_nzcv, vecs[i].estk);
            chk($sformatf("v%0d_flag_err", i), flag_err, 0);
        end
        chk("table_zero_cnt", zero_cnt, 0);

        // Zero-count saturation: 300 consistent Y=0,Z=1 pushes while draining.
        for (int k = 1; k <= 300; k++) begin
            drive(1, 4'h0, 4'b0100, 1, 0);
            tick;
            if (k == 254) chk("zc_254", zero_cnt, 254);
            if (k == 255) chk("zc_255", zero_cnt, 255);
        end
        chk("zc_sat", zero_cnt, 255);
        chk("zc_count", count, 1);
        chk("zc_sticky", sticky_nzcv, 4'b1111);
        chk("zc_flag_err", flag_err, 0);
        drive(0, 4'h0, 4'b0000, 1, 0);
        tick;
        chk("zc_drained", count, 0);

        // Flag-consistency error and clear.
        drive(1, 4'h3, 4'b0100, 1, 0);
        tick;
        chk("err_set", flag_err, 1);
        chk("err_zc_held", zero_cnt, 255);
        drive(0, 4'h0, 4'b0000, 1, 1);
        tick;
        chk("clr_err", flag_err, 0);
        chk("clr_sticky", sticky_nzcv, 0);
        chk("clr_count", count, 0);
        drive(1, 4'h3, 4'b0100, 1, 1);
        tick;
        chk("clr_push_err", flag_err, 1);
        chk("clr_push_sticky", sticky_nzcv, 4'b0100);
        drive(1, 4'h0, 4'b0000, 1, 0);
        tick;
        chk("y0_z0_err_held", flag_err, 1);
        drive(0, 4'h0, 4'b0000, 1, 1);
        tick;
        chk("clr2_err", flag_err, 0);
        chk("clr2_sticky", sticky_nzcv, 0);

        // Reset wins over a concurrent push with count=3.
        drive(0, 4'h0, 4'b0000, 1, 0);
        tick;
        for (int k = 0; k < 3; k++) begin
            drive(1, 4'h9, 4'b1001, 0, 0);
            tick;
        end
        chk("pre_rst_count", count, 3);
        chk("pre_rst_sticky", sticky_nzcv, 4'b1001);
        rst = 1'b1;
        drive(1, 4'hC, 4'b1000, 0, 0);
        tick;
        rst = 1'b0;
        chk("rst6_count", count, 0);
        chk("rst6_out_valid", out_valid, 0);
        chk("rst6_in_ready", in_ready, 1);
        chk("rst6_sticky", sticky_nzcv, 0);
        chk("rst6_zero_cnt", zero_cnt, 0);
        chk("rst6_out_y", out_y, 0);
        drive(0, 4'h0, 4'b0000, 1, 0);
        tick;
        chk("rst6_discarded", count, 0);
        chk("rst6_discard_valid", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
